elevator_dispatcher: RTL and testbench
======================================

Name: elevator_dispatcher

Overview:
- Request scheduler feeding the elevator car model.
- Latches car-button and hall-button presses into a per-floor pending set and publishes it as queue_status/queue_empty.
- Chooses the travel direction (next_up_ndown) with a collective-control scan policy.
- Clears a floor's pending request when the car signals disembark at that floor.

Parameters:
- NUM_FLOORS, 7, number of floors; floors are numbered 0..NUM_FLOORS-1.
- FLOOR_W, 3, width of floor index; must satisfy 2**FLOOR_W >= NUM_FLOORS.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- car_call  in  NUM_FLOORS  level car-panel buttons, one per floor.
- hall_up  in  NUM_FLOORS  level hall up buttons; bit NUM_FLOORS-1 ignored.
- hall_dn  in  NUM_FLOORS  level hall down buttons; bit 0 ignored.
- current_floor  in  FLOOR_W  car position.
- current_up_ndown  in  1  car's present direction.
- deassert_floor  in  1  car disembark indication, level.
- queue_status  out  NUM_FLOORS  pending request per floor.
- queue_empty  out  1  no pending requests.
- next_up_ndown  out  1  direction the car must take next; 1 = up.
- dir_state  out  2  scheduler state, for debug.

Behaviour:
- Reset (async, active-high) values: queue_status=0, queue_empty=1, next_up_ndown=1, dir_state=IDLE, all input history flops=0.
- Buttons: each input bit is registered once. A press is the rising edge (in & ~in_q). Any press at floor i sets pending[i], which is visible on queue_status one clock after the first cycle the edge is detected. Holding a button does not re-trigger.
- Clear: on a rising edge of deassert_floor, pending[current_floor] is cleared. Edge detection is required because the car holds deassert_floor high.
- Simultaneous press and clear at the same floor: clear wins, and the press is lost; the user must press again.
- current_floor >= NUM_FLOORS: treated as NUM_FLOORS-1 for clear and for comparisons.
- queue_empty is the registered NOR of pending and updates in the same cycle as queue_status.
- above = any pending[j] with j > current_floor; below = any pending[j] with j < current_floor. A request at current_floor counts as neither.
- FSM dir_state, 2'b00 IDLE:
  - Stays IDLE while empty.
  - If nonempty: go SERVE_UP when above & !below, SERVE_DN when below & !above.
  - If both above and below: go to the direction matching current_up_ndown.
  - If only the current floor is pending: go SERVE_UP when current_floor < NUM_FLOORS-1, else SERVE_DN.
- FSM dir_state, 2'b01 SERVE_UP:
  - Stays while above.
  - Else goes SERVE_DN if below.
  - Else goes IDLE when empty; otherwise (only current floor pending) stays.
- FSM dir_state, 2'b10 SERVE_DN: mirror of SERVE_UP.
- 2'b11 is unused and recovers to IDLE next cycle.
- next_up_ndown is registered: 1 in SERVE_UP, 0 in SERVE_DN, held in IDLE. It reflects a queue_status change 2 cycles after the button edge.
- Reset mid-operation clears all pending requests immediately; there is no retained state.

Optional Feature:
- Macro: FLOOR_LOCKOUT_EN.
- When defined:
  - Adds input floor_lockout[NUM_FLOORS-1:0].
  - Presses at locked floors are discarded.
  - Pending bits of locked floors are cleared each cycle.
  - Locked floors are excluded from above/below.
- When undefined: the port is absent and behaviour is as above.

Decomposition:
- Package elevator_pkg holds NUM_FLOORS/FLOOR_W constants, typedef enum logic[1:0] dir_state_t {IDLE, SERVE_UP, SERVE_DN}, and typedef logic[NUM_FLOORS-1:0] floor_mask_t.
- Sub-module elevator_call_latch (one instance per floor): edge detect for three buttons, pending flop, clear priority.

Test Plan:
- Reset with car_call=7'h04 held high: after release of reset, queue_status stays 0 (no edge across reset); release and re-press car_call[2] -> queue_status=7'h04 one cycle later, queue_empty=0.
- current_floor=1, press car_call[4] -> dir_state SERVE_UP, next_up_ndown=1 two cycles after the edge; pulse deassert_floor with current_floor=4 -> queue_status=0, queue_empty=1, dir_state IDLE.
- current_floor=3, pending floors 5 and 0, current_up_ndown=0 -> SERVE_DN; clear floor 0 -> SERVE_UP, next_up_ndown=1.
- Same-cycle rising edges of hall_up[3] and deassert_floor with current_floor=3 -> pending[3]=0; hall_dn[0] and hall_up[6] presses -> no effect.
- Hold deassert_floor high for 10 cycles while re-pressing car_call[current_floor] -> only the first edge clears; the re-press stays pending.
- With FLOOR_LOCKOUT_EN defined and floor_lockout=7'h20: press car_call[5] -> ignored; lock floor 2 while pending[2]=1 -> cleared the next cycle.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared constants and types for the elevator request scheduler.
// Optional build macro: FLOOR_LOCKOUT_EN (per-floor lockout input).
package elevator_pkg;

   localparam int NUM_FLOORS = 7;
   localparam int FLOOR_W    = 3;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      SERVE_UP = 2'b01,
      SERVE_DN = 2'b10
   } dir_state_t;

   typedef logic [NUM_FLOORS-1:0] floor_mask_t;

endpackage

// File: rtl/elevator_dispatcher_if.sv
// Button/car-position bundle between the car model and the dispatcher.
// FLOOR_LOCKOUT_EN adds the floor_lockout mask to the bundle.
interface elevator_dispatcher_if;
   import elevator_pkg::*;

   floor_mask_t          car_call;
   floor_mask_t          hall_up;
   floor_mask_t          hall_dn;
   logic [FLOOR_W-1:0]   current_floor;
   logic                 current_up_ndown;
   logic                 deassert_floor;
`ifdef FLOOR_LOCKOUT_EN
   floor_mask_t          floor_lockout;
`endif
   floor_mask_t          queue_status;
   logic                 queue_empty;
   logic                 next_up_ndown;
   logic [1:0]           dir_state;

   modport master (
`ifdef FLOOR_LOCKOUT_EN
      output floor_lockout,
`endif
      output car_call, hall_up, hall_dn,
      output current_floor, current_up_ndown,
      output deassert_floor,
      input  queue_status, queue_empty,
      input  next_up_ndown, dir_state
   );

   modport slave (
`ifdef FLOOR_LOCKOUT_EN
      input  floor_lockout,
`endif
      input  car_call, hall_up, hall_dn,
      input  current_floor, current_up_ndown,
      input  deassert_floor,
      output queue_status, queue_empty,
      output next_up_ndown, dir_state
   );

endinterface

// File: rtl/elevator_call_latch.sv
// One floor's request latch: button edge detect, pending flop,
// clear/lockout take priority over a same-cycle press.
module elevator_call_latch (
   input  logic clk,
   input  logic reset,
   input  logic arm,
   input  logic car,
   input  logic up,
   input  logic dn,
   input  logic clr,
   input  logic lock,
   output logic pend,
   output logic pend_nx
);

   logic car_q;
   logic up_q;
   logic dn_q;
   logic press;

   assign press = arm & ~lock &
                  ((car & ~car_q) |
                   (up  & ~up_q)  |
                   (dn  & ~dn_q));

   always_comb begin
      pend_nx = pend | press;
      if (clr | lock)
         pend_nx = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         car_q <= 1'b0;
         up_q  <= 1'b0;
         dn_q  <= 1'b0;
         pend  <= 1'b0;
      end else begin
         car_q <= car;
         up_q  <= up;
         dn_q  <= dn;
         pend  <= pend_nx;
      end
   end

endmodule

// File: rtl/elevator_dispatcher.sv
// Collective-control request scheduler: pending set plus scan-direction FSM.
// Optional build macro: FLOOR_LOCKOUT_EN.
module elevator_dispatcher
   import elevator_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   elevator_dispatcher_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_UP   = 2'b01;
   localparam logic [1:0] S_DN   = 2'b10;

   localparam logic [FLOOR_W-1:0] TOP_F = FLOOR_W'(NUM_FLOORS-1);

   logic               armed;
   logic               dea_q;
   logic               clr_edge;
   logic [FLOOR_W-1:0] cf;
   floor_mask_t        pend;
   floor_mask_t        pend_nx;
   floor_mask_t        lock;
   floor_mask_t        act;
   logic               above;
   logic               below;
   logic               empty;
   logic [1:0]         state;
   logic [1:0]         state_nx;
   logic               q_empty;
   logic               nxt_up;

`ifdef FLOOR_LOCKOUT_EN
   assign lock = bus.floor_lockout;
`else
   assign lock = '0;
`endif

   assign cf = (bus.current_floor > TOP_F) ? TOP_F
                                           : bus.current_floor;

   // armed masks the first cycle after reset so a held button is not an edge
   assign clr_edge = armed & bus.deassert_floor & ~dea_q;

   for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_fl
      elevator_call_latch u_latch (
         .clk     (clk),
         .reset   (reset),
         .arm     (armed),
         .car     (bus.car_call[i]),
         .up      (bus.hall_up[i] & (i < NUM_FLOORS-1)),
         .dn      (bus.hall_dn[i] & (i > 0)),
         .clr     (clr_edge & (cf == FLOOR_W'(i))),
         .lock    (lock[i]),
         .pend    (pend[i]),
         .pend_nx (pend_nx[i])
      );
   end

   assign act   = pend & ~lock;
   assign empty = ~|act;

   always_comb begin
      above = 1'b0;
      below = 1'b0;
      for (int j = 0; j < NUM_FLOORS; j++) begin
         if (act[j] && (FLOOR_W'(j) > cf)) above = 1'b1;
         if (act[j] && (FLOOR_W'(j) < cf)) below = 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (empty)
               state_nx = S_IDLE;
            else if (above && !below)
               state_nx = S_UP;
            else if (below && !above)
               state_nx = S_DN;
            else if (above && below)
               state_nx = bus.current_up_ndown ? S_UP : S_DN;
            else
               state_nx = (cf < TOP_F) ? S_UP : S_DN;
         end
         S_UP: begin
            if (above)      state_nx = S_UP;
            else if (below) state_nx = S_DN;
            else if (empty) state_nx = S_IDLE;
         end
         S_DN: begin
            if (below)      state_nx = S_DN;
            else if (above) state_nx = S_UP;
            else if (empty) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed   <= 1'b0;
         dea_q   <= 1'b0;
         state   <= S_IDLE;
         q_empty <= 1'b1;
         nxt_up  <= 1'b1;
      end else begin
         armed   <= 1'b1;
         dea_q   <= bus.deassert_floor;
         state   <= state_nx;
         q_empty <= ~|pend_nx;
         if (state_nx == S_UP)
            nxt_up <= 1'b1;
         else if (state_nx == S_DN)
            nxt_up <= 1'b0;
      end
   end

   assign bus.queue_status  = pend;
   assign bus.queue_empty   = q_empty;
   assign bus.dir_state     = state;
   assign bus.next_up_ndown = nxt_up;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed-vector bench for elevator_dispatcher.
// Define FLOOR_LOCKOUT_EN to also exercise the lockout mask.
module tb_elevator_dispatcher;
   import elevator_pkg::*;

   logic clk;
   logic reset;
   int   nvec;
   int   nbad;

   elevator_dispatcher_if bus ();

   elevator_dispatcher dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [7:0] got,
                      input logic [7:0] exp);
      nvec++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_q(input string tag, input logic [6:0] qs,
                        input logic qe);
      chk({tag, ".qs"}, {1'b0, bus.queue_status}, {1'b0, qs});
      chk({tag, ".qe"}, {7'b0, bus.queue_empty}, {7'b0, qe});
   endtask

   task automatic chk_dir(input string tag, input logic [1:0] st,
                          input logic nx);
      chk({tag, ".st"}, {6'b0, bus.dir_state}, {6'b0, st});
      chk({tag, ".nx"}, {7'b0, bus.next_up_ndown}, {7'b0, nx});
   endtask

   task automatic press_car(input int f);
      bus.car_call[f] = 1'b1;
      tick();
      bus.car_call[f] = 1'b0;
   endtask

   task automatic clear_at(input logic [2:0] f);
      bus.current_floor  = f;
      bus.deassert_floor = 1'b1;
      tick();
      bus.deassert_floor = 1'b0;
   endtask

   initial begin
      nvec = 0;
      nbad = 0;
      reset = 1'b1;
      bus.car_call = 7'h04;
      bus.hall_up = '0;
      bus.hall_dn = '0;
      bus.current_floor = 3'd1;
      bus.current_up_ndown = 1'b1;
      bus.deassert_floor = 1'b0;
`ifdef FLOOR_LOCKOUT_EN
      bus.floor_lockout = '0;
`endif
      repeat (2) tick();
      chk_q("rst", 7'h00, 1'b1);
      chk_dir("rst", 2'(IDLE), 1'b1);

      // held button across reset release is not a press
      reset = 1'b0;
      repeat (3) tick();
      chk_q("held", 7'h00, 1'b1);
      bus.car_call = '0;
      tick();
      press_car(2);
      chk_q("repress", 7'h04, 1'b0);
      tick();
      chk_dir("up2", 2'(SERVE_UP), 1'b1);
      clear_at(3'd2);
      chk_q("clr2", 7'h00, 1'b1);
      tick();
      chk_dir("idle2", 2'(IDLE), 1'b1);

      bus.current_floor = 3'd1;
      press_car(4);
      chk_q("p4", 7'h10, 1'b0);
      tick();
      chk_dir("up4", 2'(SERVE_UP), 1'b1);
      clear_at(3'd4);
      chk_q("clr4", 7'h00, 1'b1);
      tick();
      chk_dir("idle4", 2'(IDLE), 1'b1);

      // both directions pending: current direction breaks the tie
      bus.current_floor = 3'd3;
      bus.current_up_ndown = 1'b0;
      bus.car_call = 7'h21;
      tick();
      bus.car_call = '0;
      chk_q("p50", 7'h21, 1'b0);
      tick();
      chk_dir("dn50", 2'(SERVE_DN), 1'b0);
      clear_at(3'd0);
      chk_q("clr0", 7'h20, 1'b0);
      tick();
      chk_dir("up5", 2'(SERVE_UP), 1'b1);
      clear_at(3'd5);
      tick();
      chk_q("clr5", 7'h00, 1'b1);
      chk_dir("idle5", 2'(IDLE), 1'b1);

      // same-cycle press and clear: clear wins
      bus.current_floor = 3'd3;
      bus.hall_up[3] = 1'b1;
      bus.deassert_floor = 1'b1;
      tick();
      chk_q("race", 7'h00, 1'b1);
      bus.hall_up[3] = 1'b0;
      bus.deassert_floor = 1'b0;
      tick();
      bus.hall_dn[0] = 1'b1;
      bus.hall_up[6] = 1'b1;
      tick();
      chk_q("ign", 7'h00, 1'b1);
      tick();
      chk_dir("ign", 2'(IDLE), 1'b1);
      bus.hall_dn[0] = 1'b0;
      bus.hall_up[6] = 1'b0;
      tick();

      // hall_dn press sets pending
      bus.current_floor = 3'd1;
      bus.hall_dn[5] = 1'b1;
      tick();
      bus.hall_dn[5] = 1'b0;
      chk_q("hdn5", 7'h20, 1'b0);
      clear_at(3'd5);
      tick();
      chk_q("hdn5c", 7'h00, 1'b1);

      // held deassert clears only once
      bus.current_floor = 3'd2;
      press_car(2);
      chk_q("h.p", 7'h04, 1'b0);
      bus.deassert_floor = 1'b1;
      tick();
      chk_q("h.clr", 7'h00, 1'b1);
      for (int k = 0; k < 9; k++) begin
         bus.car_call[2] = (k == 2);
         tick();
      end
      chk_q("h.keep", 7'h04, 1'b0);
      bus.deassert_floor = 1'b0;
      tick();
      clear_at(3'd2);
      chk_q("h.end", 7'h00, 1'b1);
      tick();

      // out-of-range floor saturates to the top floor
      bus.current_floor = 3'd1;
      press_car(6);
      chk_q("p6", 7'h40, 1'b0);
      clear_at(3'd7);
      chk_q("clr7", 7'h00, 1'b1);
      tick();

`ifdef FLOOR_LOCKOUT_EN
      bus.current_floor = 3'd1;
      bus.floor_lockout = 7'h20;
      press_car(5);
      chk_q("lk5", 7'h00, 1'b1);
      press_car(2);
      chk_q("lk2p", 7'h04, 1'b0);
      bus.floor_lockout = 7'h24;
      tick();
      chk_q("lk2", 7'h00, 1'b1);
      bus.floor_lockout = '0;
      tick();
`endif

      // asynchronous reset drops pending immediately
      bus.current_floor = 3'd1;
      press_car(3);
      chk_q("pre", 7'h08, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk_q("arst", 7'h00, 1'b1);
      chk_dir("arst", 2'(IDLE), 1'b1);
      tick();
      reset = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
